// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode enum, default widths and
// the response record carried through the pipeline stages.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;
  localparam int ALU_TAG_WIDTH  = 4;

  typedef enum logic [7:0] {
    OP_ADD   = 8'h00,
    OP_SUB   = 8'h01,
    OP_AND   = 8'h02,
    OP_OR    = 8'h03,
    OP_XOR   = 8'h04,
    OP_SLL   = 8'h05,
    OP_SRL   = 8'h06,
    OP_SRA   = 8'h07,
    OP_SLT   = 8'h08,
    OP_SLTU  = 8'h09,
    OP_PASSB = 8'h0A,
    OP_ROL   = 8'h0B,
    OP_ROR   = 8'h0C,
    OP_MIN   = 8'h0D,
    OP_MAX   = 8'h0E,
    OP_MINU  = 8'h0F,
    OP_MAXU  = 8'h10
  } alu_op_e;

  // Stage payload at the default widths; alu_pipe declares the same layout
  // at its parameterised widths.
  typedef struct packed {
    logic [ALU_DATA_WIDTH-1:0] result;
    logic                      zero;
    logic                      ovf;
    logic                      illegal;
    logic [ALU_TAG_WIDTH-1:0]  tag;
  } alu_resp_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: opcode decode, compute and status flags.
// Ports:
//   op_i       opcode (alu_op_e encoding, undefined codes flagged illegal)
//   a_i, b_i   operands
//   result_o   result (0 for illegal opcodes)
//   zero_o     result_o == 0
//   ovf_o      signed overflow, ADD/SUB only
//   illegal_o  opcode not defined
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic [7:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  ovf_o,
  output logic                  illegal_o
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int MSB = DATA_WIDTH - 1;

  logic [SHW-1:0]          sh;
  logic [DATA_WIDTH-1:0]   sum;
  logic [DATA_WIDTH-1:0]   diff;
  logic [2*DATA_WIDTH-1:0] rol_w;
  logic [2*DATA_WIDTH-1:0] ror_w;
  logic                    lt_s;
  logic                    lt_u;
  logic [DATA_WIDTH-1:0]   res;
  logic                    ovf;
  logic                    ill;

  assign sh   = b_i[SHW-1:0];
  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
  // Rotates via a doubled operand: the wrapped bits land in the kept half.
  assign rol_w = {a_i, a_i} << sh;
  assign ror_w = {a_i, a_i} >> sh;
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    ill = 1'b0;
    case (op_i)
      OP_ADD: begin
        res = sum;
        ovf = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
      end
      OP_AND:   res = a_i & b_i;
      OP_OR:    res = a_i | b_i;
      OP_XOR:   res = a_i ^ b_i;
      OP_SLL:   res = a_i << sh;
      OP_SRL:   res = a_i >> sh;
      OP_SRA:   res = $signed(a_i) >>> sh;
      OP_SLT:   res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      OP_SLTU:  res = {{(DATA_WIDTH-1){1'b0}}, lt_u};
      OP_PASSB: res = b_i;
      OP_ROL:   res = rol_w[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_ROR:   res = ror_w[DATA_WIDTH-1:0];
      OP_MIN:   res = lt_s ? a_i : b_i;
      OP_MAX:   res = lt_s ? b_i : a_i;
      OP_MINU:  res = lt_u ? a_i : b_i;
      OP_MAXU:  res = lt_u ? b_i : a_i;
      default:  ill = 1'b1;
    endcase
  end

  assign result_o  = res;
  assign zero_o    = (res == '0);
  assign ovf_o     = ovf;
  assign illegal_o = ill;

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: one operation per cycle over valid/ready, result computed in
// front of stage 0 and carried through STAGES handshake registers.
// Ports:
//   clock, reset             clock; synchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready comb from out_ready)
//   in_op, in_a, in_b        opcode and operands
//   in_tag                   opaque tag returned with the result
//   out_valid/out_ready      output handshake
//   out_result, out_tag      result and its tag
//   out_zero, out_ovf        result == 0; signed overflow (ADD/SUB)
//   out_illegal              opcode not defined (result forced to 0)
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int STAGES     = 2,
  parameter int TAG_WIDTH  = ALU_TAG_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_zero,
  output logic                  out_ovf,
  output logic                  out_illegal
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  ovf;
    logic                  illegal;
    logic [TAG_WIDTH-1:0]  tag;
  } resp_t;

  resp_t         stage0_d;
  logic          valid_q [STAGES];
  resp_t         pay_q   [STAGES];
  logic [STAGES:0] rdy;

  logic [DATA_WIDTH-1:0] core_result;
  logic                  core_zero;
  logic                  core_ovf;
  logic                  core_illegal;

  alu_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .op_i      (in_op),
    .a_i       (in_a),
    .b_i       (in_b),
    .result_o  (core_result),
    .zero_o    (core_zero),
    .ovf_o     (core_ovf),
    .illegal_o (core_illegal)
  );

  assign stage0_d = '{result:  core_result,
                      zero:    core_zero,
                      ovf:     core_ovf,
                      illegal: core_illegal,
                      tag:     in_tag};

  // Ready ripples back from the consumer; computed top-down in one block so
  // the chain stays a single combinational process.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int unsigned k = 0; k < STAGES; k++) begin
      rdy[STAGES-1-k] = !valid_q[STAGES-1-k] || rdy[STAGES-k];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic  up_valid;
    resp_t up_pay;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_pay   = stage0_d;
    end else begin : g_body
      assign up_valid = valid_q[i-1];
      assign up_pay   = pay_q[i-1];
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        valid_q[i] <= 1'b0;
        pay_q[i]   <= '0;
      end else if (rdy[i]) begin
        valid_q[i] <= up_valid;
        if (up_valid) begin
          pay_q[i] <= up_pay;
        end
      end
    end
  end

  assign in_ready    = rdy[0];
  assign out_valid   = valid_q[STAGES-1];
  assign out_result  = pay_q[STAGES-1].result;
  assign out_zero    = pay_q[STAGES-1].zero;
  assign out_ovf     = pay_q[STAGES-1].ovf;
  assign out_illegal = pay_q[STAGES-1].illegal;
  assign out_tag     = pay_q[STAGES-1].tag;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases, backpressure, reset
// flush and a long randomized run against a behavioural reference model.
module tb_alu_pipe;

  localparam int DW  = 32;
  localparam int TW  = 4;
  localparam int STG = 3;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_op;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_tag;
  logic          out_zero;
  logic          out_ovf;
  logic          out_illegal;

  alu_pipe #(
    .DATA_WIDTH (DW),
    .STAGES     (STG),
    .TAG_WIDTH  (TW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_zero    (out_zero),
    .out_ovf     (out_ovf),
    .out_illegal (out_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] res;
    logic          z;
    logic          o;
    logic          ill;
    logic [TW-1:0] tag;
  } exp_t;

  // Reference model: plain 64-bit arithmetic on sign/zero-extended operands.
  function automatic exp_t ref_op(input logic [7:0] op, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, input logic [TW-1:0] tag);
    exp_t          e;
    longint        sa, sb, full, maxs, mins;
    longint unsigned ua, ub, mask, t;
    int            n;
    sa   = $signed(a);
    sb   = $signed(b);
    ua   = a;
    ub   = b;
    mask = (64'd1 << DW) - 1;
    maxs = (64'sd1 <<< (DW - 1)) - 1;
    mins = -maxs - 1;
    n    = int'(ub % DW);
    e.o   = 1'b0;
    e.ill = 1'b0;
    e.tag = tag;
    t     = 0;
    case (op)
      8'h00: begin full = sa + sb; t = full; e.o = (full > maxs) || (full < mins); end
      8'h01: begin full = sa - sb; t = full; e.o = (full > maxs) || (full < mins); end
      8'h02: t = ua & ub;
      8'h03: t = ua | ub;
      8'h04: t = ua ^ ub;
      8'h05: t = ua << n;
      8'h06: t = ua >> n;
      8'h07: begin full = sa >>> n; t = full; end
      8'h08: t = (sa < sb) ? 1 : 0;
      8'h09: t = (ua < ub) ? 1 : 0;
      8'h0A: t = ub;
      8'h0B: t = (ua << n) | (ua >> (DW - n));
      8'h0C: t = (ua >> n) | (ua << (DW - n));
      8'h0D: t = (sa <= sb) ? ua : ub;
      8'h0E: t = (sa >= sb) ? ua : ub;
      8'h0F: t = (ua <= ub) ? ua : ub;
      8'h10: t = (ua >= ub) ? ua : ub;
      default: begin t = 0; e.ill = 1'b1; end
    endcase
    t     = t & mask;
    e.res = t[DW-1:0];
    e.z   = (t == 0);
    return e;
  endfunction

  // Scoreboard / monitor, sampling on the falling edge.
  exp_t          sb[$];
  int unsigned   n_push = 0;
  int unsigned   n_pop  = 0;
  bit            stall_q = 1'b0;
  logic [DW-1:0] held_res;
  logic [TW-1:0] held_tag;

  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_result", out_result, held_res);
        chk("hold_tag", out_tag, held_tag);
      end
      if (out_valid && out_ready) begin
        chk("out_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          n_pop++;
          chk("sb_result", out_result, e.res);
          chk("sb_zero", out_zero, e.z);
          chk("sb_ovf", out_ovf, e.o);
          chk("sb_illegal", out_illegal, e.ill);
          chk("sb_tag", out_tag, e.tag);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_op(in_op, in_a, in_b, in_tag));
        n_push++;
      end
      stall_q  = out_valid && !out_ready;
      held_res = out_result;
      held_tag = out_tag;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single op on an empty pipe with out_ready high; checks latency and payload.
  task automatic do_op(input string name, input logic [7:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [TW-1:0] tag,
                       input logic [DW-1:0] x_res, input logic x_z, input logic x_o,
                       input logic x_ill);
    int lat;
    bit acc;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clock);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk({name, "_accept"}, acc, 1);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      lat++;
      if (out_valid) break;
    end
    chk({name, "_latency"}, lat, STG);
    chk({name, "_result"}, out_result, x_res);
    chk({name, "_zero"}, out_zero, x_z);
    chk({name, "_ovf"}, out_ovf, x_o);
    chk({name, "_illegal"}, out_illegal, x_ill);
    chk({name, "_tag"}, out_tag, tag);
    tick();
  endtask

  function automatic logic [DW-1:0] rnd_word();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int j, k, acc;
    int unsigned push0, pop0, cyc;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", out_result, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_flags", {out_zero, out_ovf, out_illegal}, 0);
    tick();

    do_op("add_ovf",  8'h00, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3, 32'h8000_0000, 0, 1, 0);
    do_op("sub_ovf",  8'h01, 32'h8000_0000, 32'h0000_0001, 4'd5, 32'h7FFF_FFFF, 0, 1, 0);
    do_op("sub_zero", 8'h01, 32'h1234_5678, 32'h1234_5678, 4'd6, 32'h0000_0000, 1, 0, 0);
    do_op("rol",      8'h0B, 32'h8000_0001, 32'd4,         4'd7, 32'h0000_0018, 0, 0, 0);
    do_op("ror",      8'h0C, 32'h8000_0001, 32'd36,        4'd8, 32'h1800_0000, 0, 0, 0);
    do_op("min",      8'h0D, 32'hFFFF_FFFF, 32'h1,         4'd9, 32'hFFFF_FFFF, 0, 0, 0);
    do_op("minu",     8'h0F, 32'hFFFF_FFFF, 32'h1,         4'd10, 32'h0000_0001, 0, 0, 0);
    do_op("maxu",     8'h10, 32'hFFFF_FFFF, 32'h1,         4'd11, 32'hFFFF_FFFF, 0, 0, 0);
    do_op("sra",      8'h07, 32'h8000_0000, 32'h0000_0024, 4'd12, 32'hF800_0000, 0, 0, 0);
    do_op("illegal",  8'h20, 32'hFFFF_FFFF, 32'h1,         4'd13, 32'h0000_0000, 1, 0, 1);

    // Backpressure: 8 back-to-back ops, consumer stalled for 6 cycles.
    j = 0;
    k = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_op    = 8'h00;
      in_a     = 32'(j * 3);
      in_b     = 32'(j);
      in_tag   = 4'(j);
      @(negedge clock);
      if (in_valid && in_ready) j++;
      tick();
    end
    chk("bp_accepted", j, STG);
    @(negedge clock);
    chk("bp_in_ready_low", in_ready, 0);
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < 40 && k < 8; c++) begin
      in_valid = (j < 8);
      in_op    = 8'h00;
      in_a     = 32'(j * 3);
      in_b     = 32'(j);
      in_tag   = 4'(j);
      @(negedge clock);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_tag", out_tag, k);
      chk("bp_out_result", out_result, 32'(k * 4));
      if (out_valid && out_ready) k++;
      if (in_valid && in_ready) j++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_drained", k, 8);

    // Reset with two ops in flight; reset also wins over a concurrent push.
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_op    = 8'h03;
      in_a     = 32'h00F0;
      in_b     = 32'(c);
      in_tag   = 4'(c + 1);
      tick();
    end
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    for (int c = 0; c < STG + 2; c++) begin
      tick();
      @(negedge clock);
      chk("flush_quiet", out_valid, 0);
    end
    tick();
    do_op("post_rst", 8'h04, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd14, 32'hF00F_F00F, 0, 0, 0);

    // Randomized run against the reference model.
    push0 = n_push;
    pop0  = n_pop;
    acc   = 0;
    cyc   = 0;
    while (acc < 10000 && cyc < 60000) begin
      int r;
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 70);
      r         = $urandom_range(0, 19);
      in_op     = (r <= 16) ? 8'(r) : 8'($urandom_range(17, 255));
      in_a      = rnd_word();
      in_b      = rnd_word();
      in_tag    = 4'($urandom);
      @(negedge clock);
      if (in_valid && in_ready) acc++;
      tick();
      cyc++;
    end
    chk("rnd_all_issued", acc, 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (sb.size() == 0 && !out_valid) break;
      tick();
    end
    chk("rnd_drain_empty", sb.size(), 0);
    chk("rnd_out_count", n_pop - pop0, n_push - push0);
    chk("rnd_final_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
